// File: rtl/uart_prog_loader.sv
// UART program loader: receives a length-prefixed, XOR-checksummed image and writes it to word memory.
// Releases core_reset_n once the image is accepted; answers with one ACK or NAK byte.
module uart_prog_loader #(
    parameter int         BAUD_DIV = 434,
    parameter int         DATA_W   = 32,
    parameter int         ADDR_W   = 12,
    parameter logic [7:0] ACK_BYTE = 8'h06,
    parameter logic [7:0] NAK_BYTE = 8'h15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx,
    output logic              tx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_reset_n,
    output logic              program_receiving,
    output logic              program_ov,
    output logic              program_done,
    output logic              program_err
);
    localparam int          BPW       = DATA_W / 8;
    localparam int          LANE_W    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [15:0] HALF_M1   = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] FULL_M1   = 16'(BAUD_DIV - 1);
    localparam logic [63:0] MAX_BYTES = (64'd1 << ADDR_W) * 64'(BPW);

    typedef enum logic [2:0] {S_LEN, S_DATA, S_SUM, S_RESP, S_DONE, S_ERR} state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;

    logic rx_s1_q, rx_s2_q, rx_s3_q;
    rx_st_t rx_st_q, rx_st_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic rx_en, rx_byte_vld, rx_ferr, start_ok;

    state_t state_q, state_d;
    logic [31:0] len_q, len_d, cnt_q, cnt_d, full_len;
    logic [1:0] len_idx_q, len_idx_d;
    logic [7:0] sum_q, sum_d, tx_dat;
    logic [DATA_W-1:0] word_q, word_d, word_nx, wdata_q, wdata_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
    logic ok_q, ok_d, ov_q, ov_d, err_q, err_d, recv_q, recv_d, we_q, we_d;
    logic go_ack, go_nak, tx_go, tx_done;

    logic tx_busy_q, tx_busy_d;
    logic [9:0] tx_sh_q, tx_sh_d;
    logic [3:0] tx_bit_q, tx_bit_d;

    assign rx_en = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_SUM);

    always_comb begin
        rx_st_d     = rx_st_q;
        rx_cnt_d    = rx_cnt_q + 16'd1;
        rx_bit_d    = rx_bit_q;
        rx_sh_d     = rx_sh_q;
        rx_byte_vld = 1'b0;
        rx_ferr     = 1'b0;
        start_ok    = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                rx_cnt_d = 16'd0;
                if (rx_s3_q && !rx_s2_q) rx_st_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF_M1) begin
                rx_cnt_d = 16'd0;
                rx_bit_d = 3'd0;
                if (rx_s2_q) begin
                    rx_st_d = RX_IDLE;
                end else begin
                    rx_st_d  = RX_DATA;
                    start_ok = 1'b1;
                end
            end
            RX_DATA: if (rx_cnt_q == FULL_M1) begin
                rx_cnt_d = 16'd0;
                rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
            end
            default: if (rx_cnt_q == FULL_M1) begin
                rx_st_d     = RX_IDLE;
                rx_byte_vld = 1'b1;
                rx_ferr     = !rx_s2_q;
            end
        endcase
        // Outside the receive states the line is ignored entirely.
        if (!rx_en) begin
            rx_st_d     = RX_IDLE;
            rx_byte_vld = 1'b0;
            start_ok    = 1'b0;
        end
    end

    assign full_len = {rx_sh_q, len_q[31:8]};

    always_comb begin
        word_nx = word_q;
        for (int i = 0; i < BPW; i++)
            if (lane_q == LANE_W'(i)) word_nx[8*i +: 8] = rx_sh_q;
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        len_idx_d = len_idx_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        word_d    = word_q;
        lane_d    = lane_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        ok_d      = ok_q;
        ov_d      = ov_q;
        err_d     = err_q;
        recv_d    = recv_q || start_ok;
        go_ack    = 1'b0;
        go_nak    = 1'b0;
        case (state_q)
            S_LEN: if (rx_byte_vld) begin
                if (rx_ferr) begin
                    err_d  = 1'b1;
                    go_nak = 1'b1;
                end else begin
                    len_d     = full_len;
                    len_idx_d = len_idx_q + 2'd1;
                    if (len_idx_q == 2'd3) begin
                        if ({32'd0, full_len} > MAX_BYTES) begin
                            ov_d   = 1'b1;
                            go_nak = 1'b1;
                        end else if (full_len == 32'd0) begin
                            state_d = S_SUM;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: if (rx_byte_vld) begin
                if (rx_ferr) begin
                    err_d  = 1'b1;
                    go_nak = 1'b1;
                end else begin
                    sum_d = sum_q ^ rx_sh_q;
                    cnt_d = cnt_q + 32'd1;
                    // A full word or the last payload byte commits the word; unfilled lanes stay zero.
                    if (int'(lane_q) == BPW - 1 || cnt_q + 32'd1 == len_q) begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = word_nx;
                        ptr_d   = ptr_q + 1'b1;
                        word_d  = '0;
                        lane_d  = '0;
                    end else begin
                        word_d = word_nx;
                        lane_d = lane_q + 1'b1;
                    end
                    if (cnt_q + 32'd1 == len_q) state_d = S_SUM;
                end
            end
            S_SUM: if (rx_byte_vld) begin
                if (!rx_ferr && rx_sh_q == sum_q) begin
                    ok_d   = 1'b1;
                    go_ack = 1'b1;
                end else begin
                    err_d  = 1'b1;
                    go_nak = 1'b1;
                end
            end
            S_RESP: if (tx_done) state_d = ok_q ? S_DONE : S_ERR;
            default: ;
        endcase
        tx_go  = go_ack || go_nak;
        tx_dat = go_ack ? ACK_BYTE : NAK_BYTE;
        if (tx_go) begin
            state_d = S_RESP;
            recv_d  = 1'b0;
        end
    end

    always_comb begin
        tx_busy_d = tx_busy_q;
        tx_sh_d   = tx_sh_q;
        tx_bit_d  = tx_bit_q;
        tx_cnt_d  = tx_cnt_q;
        tx_done   = 1'b0;
        if (tx_busy_q) begin
            if (tx_cnt_q == FULL_M1) begin
                tx_cnt_d = 16'd0;
                tx_sh_d  = {1'b1, tx_sh_q[9:1]};
                tx_bit_d = tx_bit_q + 4'd1;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_d = 1'b0;
                    tx_done   = 1'b1;
                end
            end else begin
                tx_cnt_d = tx_cnt_q + 16'd1;
            end
        end else if (tx_go) begin
            tx_busy_d = 1'b1;
            tx_sh_d   = {1'b1, tx_dat, 1'b0};
            tx_cnt_d  = 16'd0;
            tx_bit_d  = 4'd0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_s3_q   <= 1'b1;
            rx_st_q   <= RX_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            state_q   <= S_LEN;
            len_q     <= '0;
            len_idx_q <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            word_q    <= '0;
            lane_q    <= '0;
            ptr_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            ok_q      <= 1'b0;
            ov_q      <= 1'b0;
            err_q     <= 1'b0;
            recv_q    <= 1'b0;
            tx_busy_q <= 1'b0;
            tx_sh_q   <= '1;
            tx_bit_q  <= '0;
            tx_cnt_q  <= '0;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_s3_q   <= rx_s2_q;
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            state_q   <= state_d;
            len_q     <= len_d;
            len_idx_q <= len_idx_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            word_q    <= word_d;
            lane_q    <= lane_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            ok_q      <= ok_d;
            ov_q      <= ov_d;
            err_q     <= err_d;
            recv_q    <= recv_d;
            tx_busy_q <= tx_busy_d;
            tx_sh_q   <= tx_sh_d;
            tx_bit_q  <= tx_bit_d;
            tx_cnt_q  <= tx_cnt_d;
        end
    end

    assign tx                = !tx_busy_q || tx_sh_q[0];
    assign mem_we            = we_q;
    assign mem_addr          = addr_q;
    assign mem_wdata         = wdata_q;
    assign core_reset_n      = (state_q == S_DONE);
    assign program_done      = (state_q == S_DONE);
    assign program_receiving = recv_q;
    assign program_ov        = ov_q;
    assign program_err       = err_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: directed and random frames scored against a byte-position model of the protocol.
module tb_uart_prog_loader;
    localparam int BD = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx    = 1'b1;
    logic        tx, mem_we, core_reset_n;
    logic [3:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        program_receiving, program_ov, program_done, program_err;

    uart_prog_loader #(.BAUD_DIV(BD), .DATA_W(32), .ADDR_W(4)) dut (
        .clock(clock), .reset(reset), .rx(rx), .tx(tx),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_reset_n(core_reset_n), .program_receiving(program_receiving),
        .program_ov(program_ov), .program_done(program_done), .program_err(program_err)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [35:0] wr_seen[$];
    logic [7:0]  tx_seen[$];
    logic [35:0] exp_wr[$];
    logic [7:0]  exp_resp;
    logic        exp_done, exp_ov, exp_err;
    int          exp_nsend;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) if (mem_we === 1'b1) wr_seen.push_back({mem_addr, mem_wdata});

    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(negedge clock);
            if (tx === 1'b0) begin
                repeat (BD / 2) @(negedge clock);
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clock);
                    b[i] = tx;
                end
                repeat (BD) @(negedge clock);
                tx_seen.push_back(b);
            end
        end
    end

    task automatic do_reset();
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check_eq("rst_tx", tx, 1);
        check_eq("rst_we", mem_we, 0);
        check_eq("rst_addr_data", {mem_addr, mem_wdata}, 0);
        check_eq("rst_core_n", core_reset_n, 0);
        check_eq("rst_flags", {program_receiving, program_ov, program_done, program_err}, 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        rx = 1'b1;
        repeat (5) @(posedge clock);
        wr_seen.delete();
        tx_seen.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (BD) @(posedge clock);
        end
        rx = 1'b1;
    endtask

    // Walks the frame by byte position: 4 length bytes, L payload bytes, one XOR byte.
    task automatic model(input logic [7:0] fr[$], input int bad);
        logic [31:0] len, word;
        logic [7:0]  sum;
        logic        aborted;
        exp_wr.delete();
        exp_done = 0; exp_ov = 0; exp_err = 0;
        exp_nsend = fr.size();
        len = {fr[3], fr[2], fr[1], fr[0]};
        if (bad >= 0 && bad < 4) begin
            exp_err = 1; exp_nsend = bad + 1;
        end else if (len > 32'd64) begin
            exp_ov = 1; exp_nsend = 4;
        end else begin
            word = 0; sum = 0; aborted = 0;
            for (int k = 0; k < int'(len); k++) begin
                if (4 + k == bad) begin
                    exp_err = 1; exp_nsend = bad + 1; aborted = 1;
                    break;
                end
                sum = sum ^ fr[4 + k];
                word[8 * (k % 4) +: 8] = fr[4 + k];
                if (k % 4 == 3 || k == int'(len) - 1) begin
                    exp_wr.push_back({4'(k / 4), word});
                    word = 0;
                end
            end
            if (!aborted) begin
                if (bad == 4 + int'(len) || fr[4 + len] != sum) exp_err = 1;
                else exp_done = 1;
            end
        end
        exp_resp = exp_done ? 8'h06 : 8'h15;
    endtask

    // pre: 0 plain, 1 glitch on idle line first, 2 reset during payload byte 3 then replay.
    task automatic run_case(input string tag, input logic [7:0] fr[$], input int bad, input int pre);
        int t, nw;
        model(fr, bad);
        do_reset();
        if (pre == 1) begin
            rx = 1'b0;
            repeat (2) @(posedge clock);
            rx = 1'b1;
            repeat (4 * BD) @(posedge clock);
            @(negedge clock);
            check_eq({tag, ":glitch_state"},
                     {program_receiving, program_err, program_done, tx, 28'(wr_seen.size()), 28'(tx_seen.size())},
                     {4'b0001, 56'd0});
        end
        if (pre == 2) begin
            for (int i = 0; i < 6; i++) send_byte(fr[i], 1'b1);
            rx = 1'b0;
            repeat (4 * BD) @(posedge clock);
            rx = 1'b1;
            check_eq({tag, ":prereset_writes"}, wr_seen.size(), 0);
            check_eq({tag, ":prereset_recv"}, program_receiving, 1);
            do_reset();
        end
        for (int i = 0; i < exp_nsend; i++) send_byte(fr[i], i != bad);
        t = 0;
        while (tx_seen.size() == 0 && t < 2000) begin
            @(posedge clock);
            t++;
        end
        check_eq({tag, ":resp_timeout"}, t < 2000, 1);
        repeat (2 * BD) @(posedge clock);
        @(negedge clock);
        nw = wr_seen.size();
        check_eq({tag, ":nwrites"}, nw, exp_wr.size());
        for (int i = 0; i < nw && i < exp_wr.size(); i++)
            check_eq($sformatf("%s:write%0d", tag, i), wr_seen[i], exp_wr[i]);
        check_eq({tag, ":ntx"}, tx_seen.size(), 1);
        if (tx_seen.size() > 0) check_eq({tag, ":tx_byte"}, tx_seen[0], exp_resp);
        check_eq({tag, ":flags"}, {program_done, program_ov, program_err, program_receiving},
                 {exp_done, exp_ov, exp_err, 1'b0});
        check_eq({tag, ":core_reset_n"}, core_reset_n, exp_done);
        // Terminal states must ignore further traffic.
        send_byte(8'h5A, 1'b1);
        repeat (14 * BD) @(posedge clock);
        @(negedge clock);
        check_eq({tag, ":terminal_quiet"}, {28'(wr_seen.size()), 28'(tx_seen.size())},
                 {28'(nw), 28'd1});
        check_eq({tag, ":terminal_hold"}, {program_done, core_reset_n}, {exp_done, exp_done});
    endtask

    initial begin
        logic [7:0] fr[$];
        logic [7:0] b, sum;
        int len, mode, bad;

        fr = '{8'h06, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        run_case("l6", fr, -1, 0);
        run_case("l6_ferr", fr, 6, 0);
        run_case("l6_rstmid", fr, -1, 2);
        fr = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_case("l0", fr, -1, 0);
        run_case("l0_glitch", fr, -1, 1);
        fr = '{8'h41, 8'h00, 8'h00, 8'h00};
        run_case("l65_ov", fr, -1, 0);
        fr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h55, 8'h00};
        run_case("l2_badsum", fr, -1, 0);

        fr = '{8'h40, 8'h00, 8'h00, 8'h00};
        sum = 0;
        for (int i = 0; i < 64; i++) begin
            b = 8'($urandom);
            sum = sum ^ b;
            fr.push_back(b);
        end
        fr.push_back(sum);
        run_case("l64_max", fr, -1, 0);

        for (int it = 0; it < 6; it++) begin
            len  = $urandom_range(0, 68);
            mode = $urandom_range(0, 3);
            fr.delete();
            for (int i = 0; i < 4; i++) begin
                b = 8'(len >> (8 * i));
                fr.push_back(b);
            end
            sum = 0;
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                sum = sum ^ b;
                fr.push_back(b);
            end
            if (mode == 2) sum = sum ^ 8'($urandom_range(1, 255));
            fr.push_back(sum);
            bad = (mode == 3) ? $urandom_range(0, fr.size() - 1) : -1;
            run_case($sformatf("rnd%0d_l%0d_m%0d", it, len, mode), fr, bad, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 434, clocks per UART bit period (minimum 4).
REQ-002 SHALL have parameter DATA_W, default 32, memory word width in bits (multiple of 8, range 8..64).
REQ-003 SHALL have parameter ADDR_W, default 12, memory word address width.
REQ-004 SHALL have parameters ACK_BYTE, default 8'h06, and NAK_BYTE, default 8'h15, the response bytes.
REQ-005 SHALL have port clock  in  1  sole clock.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port rx  in  1  UART receive line, idle high.
REQ-008 SHALL have port tx  out  1  UART transmit line, idle high.
REQ-009 SHALL have port mem_we  out  1  one-cycle memory write strobe.
REQ-010 SHALL have port mem_addr  out  ADDR_W  word address.
REQ-011 SHALL have port mem_wdata  out  DATA_W  write data.
REQ-012 SHALL have port core_reset_n  out  1  core reset, low until load succeeds.
REQ-013 SHALL have ports program_receiving, program_ov, program_done, program_err  out  1 each  status flags.

Function
REQ-014 SHALL pass rx through a 2-flop synchroniser before any use.
REQ-015 RX: SHALL detect start on a synchronised falling edge; re-sample at BAUD_DIV/2 and return to idle if high (glitch).
REQ-016 RX: SHALL sample 8 data bits LSB first, then the stop bit, each BAUD_DIV clocks after the previous sample; stop=0 is a framing error.
REQ-017 Frame format: 4-byte length L (little-endian, 32-bit), then L payload bytes, then 1 checksum byte = XOR of all payload bytes.
REQ-018 FSM states: S_LEN, S_DATA, S_SUM, S_RESP, S_DONE, S_ERR; reset enters S_LEN.
REQ-019 S_LEN->S_DATA after the 4th length byte when L>0; ->S_SUM when L=0.
REQ-020 S_LEN: if L > 2^ADDR_W*(DATA_W/8), SHALL set program_ov, queue NAK, enter S_RESP with error outcome; no writes occur.
REQ-021 S_DATA: SHALL pack bytes little-endian (first byte in bits 7:0) and pulse mem_we once per DATA_W/8 bytes.
REQ-022 The final payload byte SHALL flush a partial word with unfilled upper bytes zero.
REQ-023 mem_addr SHALL start at 0 and increment by 1 after each write; mem_addr/mem_wdata valid only while mem_we=1.
REQ-024 S_DATA->S_SUM after byte L; S_SUM compares the received byte to the running XOR.
REQ-025 Match: queue ACK_BYTE; mismatch: set program_err, queue NAK_BYTE; both enter S_RESP.
REQ-026 Framing error in S_LEN/S_DATA/S_SUM SHALL set program_err, queue NAK_BYTE, enter S_RESP.
REQ-027 TX: SHALL send start 0, 8 data bits LSB first, stop 1, each bit BAUD_DIV clocks.
REQ-028 S_RESP SHALL move to S_DONE (success) or S_ERR (error) in the cycle after the TX stop bit ends.
REQ-029 S_DONE SHALL assert program_done and drive core_reset_n high from its entry cycle onward.
REQ-030 S_DONE and S_ERR are terminal until reset; rx activity there is ignored (no writes, no tx).
REQ-031 program_receiving SHALL go high in the cycle the first start bit is confirmed, and low on entering S_RESP.
REQ-032 program_ov and program_err SHALL be sticky until reset; core_reset_n stays low in S_ERR.
REQ-033 The length counter is 32-bit; the checksum is 8-bit XOR; the word address wraps never (REQ-020 guarantees bound).

Reset
REQ-034 reset low SHALL asynchronously force tx=1, mem_we=0, mem_addr=0, mem_wdata=0, core_reset_n=0, all status flags 0, FSM=S_LEN, RX/TX idle.
REQ-035 reset low mid-frame or mid-response SHALL discard the partial state; after release the next byte is length byte 0.

Verification (bench uses BAUD_DIV=8, DATA_W=32, ADDR_W=4)
REQ-036 Send L=6, payload 11 22 33 44 55 66, sum 0x77 -> writes addr0=0x44332211, addr1=0x00006655; tx sends 0x06; program_done=1; core_reset_n=1.
REQ-037 Send L=0, sum 0x00 -> no mem_we; tx sends 0x06; program_done=1.
REQ-038 Send L=65 (limit 64) -> program_ov=1, no mem_we, tx sends 0x15, core_reset_n stays 0.
REQ-039 Send L=2, payload AA 55, sum 0x00 (expected 0xFF) -> one write 0x000055AA, program_err=1, tx sends 0x15.
REQ-040 Payload byte with stop bit 0 -> program_err=1, tx 0x15; 2-clock rx low pulse while idle -> ignored, no state change.
REQ-041 Assert reset during payload byte 3 of REQ-036, then replay full frame -> identical result to REQ-036.
